// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: display modes,
// segment codes, update-FSM states and the decimal display limit.
package seg_pkg;

    localparam logic [1:0] MODE_HEX   = 2'b00;
    localparam logic [1:0] MODE_DEC   = 2'b01;
    localparam logic [1:0] MODE_BLANK = 2'b10;

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [31:0] DEC_MAX = 32'd99_999_999;
    localparam int CONV_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD
    } state_t;

    // Active-low segments, dp (bit 7) always off.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] s;
        s = SEG_BLANK;
        unique case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_bin2bcd.sv
// Multi-cycle binary to BCD converter (double dabble), 32 shifts.
// The first shift happens on the start edge so bcd settles 31 edges later.
module bin2bcd
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic [39:0] bcd
);

    logic [31:0] sr;
    logic [4:0]  cnt;
    logic [39:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            sr   <= '0;
            bcd  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= 5'd1;
            sr   <= value << 1;
            bcd  <= {39'd0, value[31]};
        end else if (busy) begin
            bcd <= (adj << 1) | 40'(sr[31]);
            sr  <= sr << 1;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(CONV_CYCLES - 1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver with hex/decimal/blank modes.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros in decimal mode.
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int NDIG    = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value_i,
    input  logic [1:0]  mode_i,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o,
    output logic        busy_o
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [3:0]    disp_nib [NDIG];
    logic [7:0]    disp_blank;
    logic [7:0]    disp_dash;
    logic [31:0]   sh_value;
    logic [1:0]    sh_mode;
    state_t        state;
    logic          pend_hex;
    logic          pend_blank;
    logic          changed;
    logic          start;
    logic          b_busy;
    logic [39:0]   bcd;
    logic          ovf;
    logic [7:0]    lz_mask;
    logic [7:0]    seg_next;
    logic          unused_bcd_hi;

    assign changed = (state == ST_IDLE)
                   && ({value_i, mode_i} != {sh_value, sh_mode});
    assign start   = changed && (mode_i == MODE_DEC);
    assign ovf     = sh_value > DEC_MAX;
    assign unused_bcd_hi = ^bcd[39:32];

    bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value_i),
        .busy  (b_busy),
        .bcd   (bcd)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic seen;
    always_comb begin
        lz_mask = '0;
        seen = 1'b0;
        for (int k = NDIG - 1; k > 0; k--) begin
            seen = seen | (bcd[4*k +: 4] != 4'd0);
            lz_mask[k] = ~seen;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        if (disp_blank[idx])
            seg_next = SEG_BLANK;
        else if (disp_dash[idx])
            seg_next = SEG_DASH;
        else
            seg_next = seg_encode(disp_nib[idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            idx        <= '0;
            an_o       <= 8'hFF;
            seg_o      <= 8'hFF;
            busy_o     <= 1'b0;
            for (int k = 0; k < NDIG; k++)
                disp_nib[k] <= '0;
            disp_blank <= '0;
            disp_dash  <= '0;
            sh_value   <= '0;
            sh_mode    <= MODE_HEX;
            state      <= ST_IDLE;
            pend_hex   <= 1'b0;
            pend_blank <= 1'b0;
        end else begin
            if (div == DW'(CLK_DIV - 1)) begin
                div <= '0;
                idx <= idx + 3'd1;
            end else begin
                div <= div + DW'(1);
            end
            an_o  <= ~(8'd1 << idx);
            seg_o <= seg_next;

            // Hex/blank captures land in the buffer one cycle later.
            pend_hex   <= 1'b0;
            pend_blank <= 1'b0;
            if (pend_hex) begin
                for (int k = 0; k < NDIG; k++)
                    disp_nib[k] <= sh_value[4*k +: 4];
                disp_blank <= '0;
                disp_dash  <= '0;
            end
            if (pend_blank)
                disp_blank <= '1;

            unique case (state)
                ST_IDLE: begin
                    if (changed) begin
                        sh_value <= value_i;
                        sh_mode  <= mode_i;
                        if (mode_i[1]) begin
                            pend_blank <= 1'b1;
                        end else if (mode_i == MODE_DEC) begin
                            state  <= ST_CONV;
                            busy_o <= 1'b1;
                        end else begin
                            pend_hex <= 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    if (!b_busy)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    for (int k = 0; k < NDIG; k++)
                        disp_nib[k] <= bcd[4*k +: 4];
                    disp_dash  <= ovf ? 8'hFF : 8'h00;
                    disp_blank <= ovf ? 8'h00 : lz_mask;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan with CLK_DIV = 4.
// Digit timing is tracked by a cycle counter started at reset release.
module tb_seg_scan;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value_i = '0;
    logic [1:0]  mode_i = 2'b00;
    logic [7:0]  an_o;
    logic [7:0]  seg_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n;
    logic [7:0] exp_d [8];
    logic [7:0] lz;

    seg_scan #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .mode_i  (mode_i),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int model_digit();
        return ((cyc - 1) / CLK_DIV) % 8;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs,
                          input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_scan(input string tag, input logic [7:0] exp_seg);
        logic [7:0] ea;
        ea = ~(8'd1 << model_digit());
        check8({tag, "_an"}, an_o, ea);
        check8({tag, "_seg"}, seg_o, exp_seg);
    endtask

    task automatic goto_digit(input int k);
        int w = 0;
        while (model_digit() != k && w < 40) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic check_digits(input string tag);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            goto_digit(k);
            check_scan($sformatf("%s_d%0d", tag, k), exp_d[k]);
            check8($sformatf("%s_busy%0d", tag, k), {7'd0, busy_o}, 8'h00);
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (busy_o === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz = 8'hFF;
`else
        lz = 8'hC0;
`endif
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check8("rst_an", an_o, 8'hFF);
        check8("rst_seg", seg_o, 8'hFF);
        check8("rst_busy", {7'd0, busy_o}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check8("first_an", an_o, 8'hFE);
        for (int i = 0; i < 9; i++) begin
            check_scan($sformatf("scan%0d", i), 8'hC0);
            repeat (CLK_DIV) @(negedge clk);
        end

        // Hex: write lands exactly one cycle after capture
        exp_d = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        value_i = 32'h1234ABCD;
        mode_i  = 2'b00;
        @(negedge clk);
        check8("hex_busy_cap", {7'd0, busy_o}, 8'h00);
        @(negedge clk);
        check_scan("hex_edge_old", 8'hC0);
        @(negedge clk);
        check_scan("hex_edge_new", exp_d[model_digit()]);
        check8("hex_busy_wr", {7'd0, busy_o}, 8'h00);
        check_digits("hex");

        // Decimal 12345678
        value_i = 32'd12345678;
        mode_i  = 2'b01;
        count_busy(n);
        check_int("dec_busy_len", n, 33);
        check_scan("dec_edge_old", exp_d[model_digit()]);
        exp_d = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        @(negedge clk);
        check_scan("dec_edge_new", exp_d[model_digit()]);
        check_digits("dec");

        // Decimal 42, leading-zero behaviour depends on build
        value_i = 32'd42;
        count_busy(n);
        check_int("d42_busy_len", n, 33);
        exp_d = '{8'hA4, 8'h99, lz, lz, lz, lz, lz, lz};
        check_digits("d42");

        // Overflow
        value_i = 32'd100_000_000;
        count_busy(n);
        check_int("ovf_busy_len", n, 33);
        exp_d = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        check_digits("ovf");

        // Decimal 5, switch to blank during conversion
        value_i = 32'd5;
        mode_i  = 2'b01;
        n = 0;
        @(negedge clk);
        while (busy_o === 1'b1 && n < 100) begin
            n++;
            if (n == 5) mode_i = 2'b10;
            @(negedge clk);
        end
        check_int("blk_busy_len", n, 33);
        @(negedge clk);
        check_scan("blk_five_a", (model_digit() == 0) ? 8'h92 : lz);
        check8("blk_busy", {7'd0, busy_o}, 8'h00);
        @(negedge clk);
        check_scan("blk_five_b", (model_digit() == 0) ? 8'h92 : lz);
        @(negedge clk);
        check_scan("blk_now", 8'hFF);
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            check_scan($sformatf("blk_scan%0d", i), 8'hFF);
        end

        // Reset mid-conversion
        value_i = 32'd87654321;
        mode_i  = 2'b01;
        n = 0;
        @(negedge clk);
        while (busy_o === 1'b1 && n < 10) begin
            n++;
            if (n < 10) @(negedge clk);
        end
        check_int("rmid_busy_seen", n, 10);
        rst = 1'b1;
        value_i = '0;
        mode_i  = 2'b00;
        @(negedge clk);
        check8("rmid_busy", {7'd0, busy_o}, 8'h00);
        check8("rmid_an", an_o, 8'hFF);
        check8("rmid_seg", seg_o, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        check_scan("rmid_first", 8'hC0);
        exp_d = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        check_digits("rmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
